// File: rtl/td4_run_ctrl.sv
// TD4 execution controller: conditions the board buttons, sequences run/halt/step/break
// and emits a one-cycle CPU clock enable at a selectable rate.
module td4_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DIV_SLOW        = 25000000,
  parameter int DIV_MID         = 2500000,
  parameter int DIV_FAST        = 25000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_reset,
  input  logic [1:0]       speed_sel,
  input  logic             bp_en,
  input  logic [3:0]       bp_addr,
  input  logic [3:0]       pc,
  output logic             cpu_ce,
  output logic             cpu_n_reset,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int PS_W = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // The CPU-reset button starts out "pressed" so the CPU stays in reset until the
  // button is proven released after power-up.
  localparam logic [2:0] DEB_INIT = 3'b100;

  // Button index: 0 = run, 1 = step, 2 = CPU reset.
  logic [2:0]      raw;
  logic [2:0]      sync1, sync2, deb, deb_q;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      press;

  assign raw = {btn_reset, btn_step, btn_run};

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= DEB_INIT;
      deb_q <= DEB_INIT;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  logic cpu_rst, run_press, step_press;
  assign cpu_rst    = deb[2];
  assign run_press  = press[0] & ~cpu_rst;
  assign step_press = press[1] & ~cpu_rst;

  state_t state_q, state_d;
  logic [PS_W-1:0] presc, div_last;
  logic [1:0]      speed_q;
  logic            ce_tick, ce_q, bp_hit;

  always_comb begin
    div_last = '0;
    case (speed_sel)
      2'd0:    div_last = PS_W'(DIV_SLOW - 1);
      2'd1:    div_last = PS_W'(DIV_MID - 1);
      2'd2:    div_last = PS_W'(DIV_FAST - 1);
      default: div_last = '0;
    endcase
  end

  assign ce_tick = (speed_sel == 2'd3) | (presc == div_last);
  assign cpu_ce  = ~cpu_rst & ((state_q == ST_STEP) | ((state_q == ST_RUN) & ce_tick));

  // The PC has advanced by the cycle after a pulse, so the compare looks one cycle late.
  assign bp_hit = (state_q == ST_RUN) & ce_q & bp_en & (pc == bp_addr);

  // NOTE: next state is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT, ST_BREAK: begin
        if (run_press)       state_d = ST_RUN;
        else if (step_press) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (run_press)   state_d = ST_HALT;
        else if (bp_hit) state_d = ST_BREAK;
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    if (cpu_rst) state_d = ST_HALT;
  end

  // NOTE: every register here has a defined async reset value; there is no
  // memory array, so nothing is left to power up undefined.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= ST_HALT;
      presc       <= '0;
      speed_q     <= '0;
      ce_q        <= 1'b0;
      cpu_n_reset <= 1'b0;
      step_count  <= '0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_sel;
      ce_q        <= cpu_ce;
      cpu_n_reset <= ~cpu_rst;

      if (cpu_rst || state_q != ST_RUN || speed_sel != speed_q || presc == div_last)
        presc <= '0;
      else
        presc <= presc + PS_W'(1);

      if (cpu_rst)
        step_count <= '0;
      else if (cpu_ce && step_count != '1)
        step_count <= step_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// Directed bench for td4_run_ctrl with short debounce/divider settings and a
// behavioural PC that advances on every cpu_ce.
module tb_td4_run_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             n_reset;
  logic             btn_run, btn_step, btn_reset;
  logic [1:0]       speed_sel;
  logic             bp_en;
  logic [3:0]       bp_addr;
  logic [3:0]       pc;
  logic             cpu_ce, cpu_n_reset;
  logic [1:0]       state;
  logic [CNT_W-1:0] step_count;

  int checks = 0;
  int errors = 0;

  td4_run_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DIV_SLOW(8),
    .DIV_MID(4),
    .DIV_FAST(2),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .btn_reset(btn_reset),
    .speed_sel(speed_sel),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .pc(pc),
    .cpu_ce(cpu_ce),
    .cpu_n_reset(cpu_n_reset),
    .state(state),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // CPU program counter model: cleared by CPU reset, advances on each enable.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset)          pc <= 4'd0;
    else if (!cpu_n_reset) pc <= 4'd0;
    else if (cpu_ce)       pc <= pc + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (state == s) break;
      tick();
    end
    check(tag, 32'(state), 32'(s));
  endtask

  task automatic wait_nrst(input logic v, input int limit, input string tag);
    for (int i = 0; i < limit; i++) begin
      if (cpu_n_reset == v) break;
      tick();
    end
    check(tag, 32'(cpu_n_reset), 32'(v));
  endtask

  int         ce_cnt;
  logic [1:0] ce_state;
  logic       saw_step;

  initial begin
    n_reset   = 1'b0;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    btn_reset = 1'b0;
    speed_sel = 2'd0;
    bp_en     = 1'b0;
    bp_addr   = 4'd0;
    ticks(3);

    // Reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_ce", 32'(cpu_ce), 32'd0);
    check("rst_cpu_nrst", 32'(cpu_n_reset), 32'd0);
    check("rst_count", 32'(step_count), 32'd0);
    n_reset = 1'b1;
    tick();
    check("nrst_held_low", 32'(cpu_n_reset), 32'd0);
    wait_nrst(1'b1, 20, "nrst_release");
    check("idle_state", 32'(state), 32'd0);

    // Bouncing step button: exactly one pulse, taken in STEP
    ce_cnt   = 0;
    ce_state = 2'd0;
    btn_step = 1'b1; ticks(2);
    btn_step = 1'b0; ticks(2);
    btn_step = 1'b1; ticks(2);
    for (int i = 0; i < 30; i++) begin
      if (cpu_ce) begin
        ce_cnt++;
        ce_state = state;
      end
      tick();
    end
    check("bounce_ce_count", 32'(ce_cnt), 32'd1);
    check("bounce_ce_in_step", 32'(ce_state), 32'd2);
    check("bounce_back_halt", 32'(state), 32'd0);
    check("bounce_count", 32'(step_count), 32'd1);
    btn_step = 1'b0;
    ticks(10);
    check("release_no_step", 32'(step_count), 32'd1);

    // Run at speed 1: pulses on RUN cycles 4, 8, 12
    speed_sel = 2'd1;
    btn_run   = 1'b1;
    wait_state(2'd1, 20, "run_entry");
    for (int k = 1; k <= 12; k++) begin
      check($sformatf("div4_ce_c%0d", k), 32'(cpu_ce), 32'((k % 4) == 0));
      tick();
    end
    check("div4_count", 32'(step_count), 32'd4);

    // Switch to every-cycle mode mid-run
    speed_sel = 2'd3;
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("fast_ce_%0d", k), 32'(cpu_ce), 32'd1);
      tick();
    end
    btn_run = 1'b0;
    ticks(10);
    check("still_run", 32'(state), 32'd1);
    btn_run = 1'b1;
    wait_state(2'd0, 20, "run_to_halt");
    check("halt_ce", 32'(cpu_ce), 32'd0);
    check("count_saturated", 32'(step_count), 32'hF);
    btn_run = 1'b0;
    ticks(10);

    // Run and step together from HALT: run wins, no STEP cycle
    saw_step = 1'b0;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'd2) saw_step = 1'b1;
      if (state != 2'd0) break;
      tick();
    end
    check("prio_run", 32'(state), 32'd1);
    check("prio_no_step", 32'(saw_step), 32'd0);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    ticks(10);
    btn_step = 1'b1;
    ticks(12);
    check("step_ignored_in_run", 32'(state), 32'd1);
    btn_step = 1'b0;
    btn_run  = 1'b1;
    wait_state(2'd0, 20, "prio_halt");
    btn_run = 1'b0;
    ticks(10);

    // CPU reset pulse clears count and PC
    btn_reset = 1'b1;
    wait_nrst(1'b0, 20, "cpurst_assert");
    btn_reset = 1'b0;
    wait_nrst(1'b1, 20, "cpurst_release");
    check("cpurst_count", 32'(step_count), 32'd0);
    check("cpurst_pc", 32'(pc), 32'd0);

    // Breakpoint at PC 5
    speed_sel = 2'd1;
    bp_en     = 1'b1;
    bp_addr   = 4'd5;
    btn_run   = 1'b1;
    wait_state(2'd1, 20, "bp_run_entry");
    for (int i = 0; i < 40; i++) begin
      if (pc == 4'd5) break;
      tick();
    end
    check("bp_pc_reached", 32'(pc), 32'd5);
    check("bp_still_run", 32'(state), 32'd1);
    tick();
    check("bp_break", 32'(state), 32'd3);
    check("bp_break_ce", 32'(cpu_ce), 32'd0);
    check("bp_count", 32'(step_count), 32'd5);
    btn_run = 1'b0;
    ticks(10);
    check("bp_hold", 32'(state), 32'd3);
    check("bp_hold_pc", 32'(pc), 32'd5);
    btn_step = 1'b1;
    wait_state(2'd2, 20, "bp_step");
    tick();
    check("bp_step_halt", 32'(state), 32'd0);
    check("bp_step_pc", 32'(pc), 32'd6);
    btn_step = 1'b0;
    bp_en    = 1'b0;
    ticks(10);

    // CPU reset mid-RUN overrides everything
    btn_run = 1'b1;
    wait_state(2'd1, 20, "mid_run_entry");
    btn_run = 1'b0;
    ticks(10);
    btn_reset = 1'b1;
    wait_nrst(1'b0, 20, "mid_cpurst");
    check("mid_cpurst_state", 32'(state), 32'd0);
    check("mid_cpurst_count", 32'(step_count), 32'd0);
    check("mid_cpurst_ce", 32'(cpu_ce), 32'd0);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("held_state_%0d", i), 32'(state), 32'd0);
      check($sformatf("held_ce_%0d", i), 32'(cpu_ce), 32'd0);
    end
    btn_run  = 1'b0;
    btn_step = 1'b0;
    ticks(10);
    btn_reset = 1'b0;
    wait_nrst(1'b1, 20, "mid_cpurst_release");
    ticks(5);
    check("post_cpurst_state", 32'(state), 32'd0);
    check("post_cpurst_count", 32'(step_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
